// File: rtl/pipeline_width_reducer_if.sv
// Handshake bundle for pipeline_width_reducer: wide upstream port plus narrow downstream port.
// output_last exists only when PIPELINE_WIDTH_REDUCER_LAST_EN is defined.
interface pipeline_width_reducer_if #(
  parameter int NARROW_WIDTH = 0,
  parameter int RATIO        = 0
);
  logic                            input_valid;
  logic                            input_ready;
  logic [NARROW_WIDTH*RATIO-1:0]   input_data;
  logic                            output_valid;
  logic                            output_ready;
  logic [NARROW_WIDTH-1:0]         output_data;
`ifdef PIPELINE_WIDTH_REDUCER_LAST_EN
  logic                            output_last;
`endif

  modport master (
`ifdef PIPELINE_WIDTH_REDUCER_LAST_EN
    input  output_last,
`endif
    output input_valid, input_data, output_ready,
    input  input_ready, output_valid, output_data
  );

  modport slave (
`ifdef PIPELINE_WIDTH_REDUCER_LAST_EN
    output output_last,
`endif
    input  input_valid, input_data, output_ready,
    output input_ready, output_valid, output_data
  );
endinterface

// File: rtl/pipeline_width_reducer.sv
// Ready/valid wide-to-narrow serializer, LSB slice first, registered output, no bubbles.
// Optional output_last beat marker enabled by PIPELINE_WIDTH_REDUCER_LAST_EN.
module pipeline_width_reducer #(
  parameter int NARROW_WIDTH = 0,
  parameter int RATIO        = 0,
  parameter int WIDE_WIDTH   = NARROW_WIDTH * RATIO
) (
  input  logic                          clock,
  input  logic                          clear,
  pipeline_width_reducer_if.slave       bus
);
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  logic [WIDE_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  last_beat, in_rdy, in_fire, out_fire;

  always_comb begin
    data_d    = data_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    last_beat = (cnt_q == LAST_CNT);
    // Only the final beat lets output_ready reach input_ready, allowing a same-cycle reload.
    in_rdy    = !clear && (!busy_q || (bus.output_ready && last_beat));
    in_fire   = bus.input_valid && in_rdy;
    out_fire  = busy_q && bus.output_ready;

    if (in_fire) begin
      data_d = bus.input_data;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (out_fire) begin
      if (!last_beat) begin
        data_d = data_q >> NARROW_WIDTH;
        cnt_d  = cnt_q + CNT_W'(1);
      end else begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      data_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign bus.input_ready  = in_rdy;
  assign bus.output_valid = busy_q;
  assign bus.output_data  = data_q[NARROW_WIDTH-1:0];

`ifdef PIPELINE_WIDTH_REDUCER_LAST_EN
  logic last_q, last_d;

  always_comb begin
    last_d = busy_d && (cnt_d == LAST_CNT);
  end

  always_ff @(posedge clock) begin
    if (clear) last_q <= 1'b0;
    else       last_q <= last_d;
  end

  assign bus.output_last = last_q;
`endif
endmodule
